// File: rtl/ita_output_buffer.sv
// Output staging buffer for the ITA datapath: per-lane masking, small FIFO and tile-boundary tracking.
// Optional same-cycle bypass when empty is enabled with `define ITA_OUT_BYPASS_EN.
module ita_output_buffer #(
    parameter int unsigned N     = 16,
    parameter int unsigned WO    = 8,
    parameter int unsigned M     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [N*WO-1:0]              data_i,
    input  logic [N-1:0]                 mask_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [N*WO-1:0]              data_o,
    output logic                         tile_done_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         overflow_o
);

    localparam int unsigned DW    = N * WO;
    localparam int unsigned BEATS = (M * M) / N;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned UW    = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [UW-1:0] count;
    logic [CW-1:0] beat_cnt;
    logic          overflow_q;

    logic [DW-1:0] masked;
    logic          full;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Disabled lanes are forced to zero before the beat is stored or bypassed.
    always_comb begin
        masked = data_i;
        for (int i = 0; i < int'(N); i++) begin
            if (!mask_i[i]) begin
                masked[i*WO +: WO] = '0;
            end
        end
    end

    assign full  = (count == UW'(DEPTH));
    assign empty = (count == '0);

`ifdef ITA_OUT_BYPASS_EN
    assign bypass = empty && valid_i && ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign ready_o = !full;
    assign push    = valid_i && !full;
    assign valid_o = !empty || bypass;
    assign pop     = valid_o && ready_i;
    assign wr_en   = push && !bypass;
    assign rd_en   = pop && !bypass;

    assign data_o      = bypass ? masked : (empty ? '0 : mem[rd_ptr]);
    assign tile_done_o = pop && (beat_cnt == CW'(BEATS - 1));
    assign usage_o     = count;
    assign overflow_o  = overflow_q;

    // Storage is not reset; only the valid region addressed by the pointers matters.
    always_ff @(posedge clk_i) begin
        if (wr_en && !clear_i) begin
            mem[wr_ptr] <= masked;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_en && !rd_en) begin
                count <= count + UW'(1);
            end else if (!wr_en && rd_en) begin
                count <= count - UW'(1);
            end
            // Beat counter follows the output handshake, bypassed beats included.
            if (pop) begin
                beat_cnt <= tile_done_o ? '0 : beat_cnt + CW'(1);
            end
            if (valid_i && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ita_output_buffer.sv
// Directed self-checking bench for ita_output_buffer (N=16, WO=8, M=64, DEPTH=2).
module tb_ita_output_buffer;

    localparam int unsigned N     = 16;
    localparam int unsigned WO    = 8;
    localparam int unsigned M     = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = N * WO;
    localparam int unsigned UW    = $clog2(DEPTH + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          clear_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic [N-1:0]  mask_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic          tile_done_o;
    logic [UW-1:0] usage_o;
    logic          overflow_o;

    int checks   = 0;
    int failures = 0;

    ita_output_buffer #(.N(N), .WO(WO), .M(M), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .mask_i      (mask_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .tile_done_o (tile_done_o),
        .usage_o     (usage_o),
        .overflow_o  (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        mask_i  = '1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    // Streams n beats (beat k carries value k) with ready_i high and records handshake results.
    task automatic stream_beats(input int n, output int pops, output int done_cnt,
                                output int done_at, output int data_errs, output bit timeout);
        int   pushed;
        int   cyc;
        logic acc;
        pushed = 0; pops = 0; done_cnt = 0; done_at = -1; data_errs = 0; cyc = 0;
        ready_i = 1'b1;
        mask_i  = '1;
        while (pops < n && cyc < 4 * n + 20) begin
            valid_i = (pushed < n);
            data_i  = DW'(pushed);
            @(negedge clk_i);
            acc = valid_i && ready_o;
            if (valid_o && ready_i) begin
                if (data_o !== DW'(pops)) data_errs++;
                pops++;
                if (tile_done_o) begin
                    done_cnt++;
                    done_at = pops;
                end
            end else if (tile_done_o) begin
                done_cnt++;
            end
            if (acc) pushed++;
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        timeout = (pops < n);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        data_i = '0; mask_i = '1;
        repeat (2) @(negedge clk_i);
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (usage_o !== '0) begin failures++; $display("FAIL reset_usage got=%0d exp=0", usage_o); end
        checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
        checks++; if (tile_done_o !== 1'b0 || overflow_o !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b exp=00", tile_done_o, overflow_o);
        end
        rst_ni = 1'b1;
        tick();
        valid_i = 1'b1;
        data_i  = {16{8'h0F}};
        mask_i  = 16'hFFFF;
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== {16{8'h0F}}) begin failures++; $display("FAIL first_data got=%h exp=%h", data_o, {16{8'h0F}}); end
        checks++; if (usage_o !== UW'(1)) begin failures++; $display("FAIL first_usage got=%0d exp=1", usage_o); end
    endtask

    task automatic test_masking();
        apply_reset();
        valid_i = 1'b1; data_i = {16{8'h7F}}; mask_i = 16'h00FF;
        tick();
        data_i = {16{8'hC3}}; mask_i = 16'h8001;
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (data_o !== {{8{8'h00}}, {8{8'h7F}}}) begin
            failures++; $display("FAIL mask_00ff got=%h exp=%h", data_o, {{8{8'h00}}, {8{8'h7F}}});
        end
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (data_o !== 128'hC3000000_00000000_00000000_000000C3) begin
            failures++; $display("FAIL mask_8001 got=%h exp=%h", data_o, 128'hC3000000_00000000_00000000_000000C3);
        end
        checks++; if (usage_o !== UW'(1)) begin failures++; $display("FAIL mask_usage got=%0d exp=1", usage_o); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        valid_i = 1'b1; data_i = {16{8'hA1}};
        tick();
        data_i = {16{8'hB2}};
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", ready_o); end
        tick();
        data_i = {16{8'hC3}};
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", ready_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL bp_ovf_early got=%b exp=0", overflow_o); end
        tick();
        @(negedge clk_i);
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", overflow_o); end
        checks++; if (usage_o !== UW'(2)) begin failures++; $display("FAIL bp_usage got=%0d exp=2", usage_o); end
        checks++; if (data_o !== {16{8'hA1}}) begin failures++; $display("FAIL bp_head got=%h exp=%h", data_o, {16{8'hA1}}); end
        // Full FIFO refuses a push even while popping in the same cycle.
        tick();
        data_i = {16{8'hD4}}; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (usage_o !== UW'(1)) begin failures++; $display("FAIL bp_refuse_usage got=%0d exp=1", usage_o); end
        checks++; if (data_o !== {16{8'hB2}}) begin failures++; $display("FAIL bp_second got=%h exp=%h", data_o, {16{8'hB2}}); end
        tick();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0 || usage_o !== '0) begin
            failures++; $display("FAIL bp_drain got valid=%b usage=%0d exp valid=0 usage=0", valid_o, usage_o);
        end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%b exp=1", overflow_o); end
        ready_i = 1'b0;
    endtask

    task automatic test_streaming();
        int pops, done_cnt, done_at, errs;
        bit to;
        apply_reset();
        stream_beats(257, pops, done_cnt, done_at, errs, to);
        checks++; if (to) begin failures++; $display("FAIL stream_timeout pops=%0d exp=257", pops); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stream_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_at !== 256) begin failures++; $display("FAIL stream_done_pop got=%0d exp=256", done_at); end
        checks++; if (errs !== 0) begin failures++; $display("FAIL stream_data errors=%0d exp=0", errs); end
        // Counter restarted at the 257th beat, so 255 more complete the next tile.
        stream_beats(255, pops, done_cnt, done_at, errs, to);
        checks++; if (to || done_cnt !== 1 || done_at !== 255) begin
            failures++; $display("FAIL stream_wrap got done=%0d at=%0d exp done=1 at=255", done_cnt, done_at);
        end
    endtask

    task automatic test_clear();
        int pops, done_cnt, done_at, errs;
        bit to;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            valid_i = 1'b1; ready_i = 1'b0; data_i = DW'(k);
            tick();
            valid_i = 1'b0; ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
        end
        valid_i = 1'b1;
        repeat (3) tick();
        valid_i = 1'b0; ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (usage_o !== UW'(1) || overflow_o !== 1'b1) begin
            failures++; $display("FAIL clear_setup got usage=%0d ovf=%b exp usage=1 ovf=1", usage_o, overflow_o);
        end
        tick();
        clear_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = {16{8'hEE}};
        tick();
        clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (usage_o !== '0) begin failures++; $display("FAIL clear_usage got=%0d exp=0", usage_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL clear_valid got=%b exp=0", valid_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%b exp=0", overflow_o); end
        tick();
        stream_beats(256, pops, done_cnt, done_at, errs, to);
        checks++; if (to || done_cnt !== 1 || done_at !== 256) begin
            failures++; $display("FAIL clear_tile got done=%0d at=%0d exp done=1 at=256", done_cnt, done_at);
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL clear_data errors=%0d exp=0", errs); end
    endtask

    task automatic test_bypass();
        apply_reset();
        valid_i = 1'b1; ready_i = 1'b1; data_i = {16{8'h5A}}; mask_i = 16'h0F0F;
        @(negedge clk_i);
`ifdef ITA_OUT_BYPASS_EN
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== {{4{8'h00}}, {4{8'h5A}}, {4{8'h00}}, {4{8'h5A}}}) begin
            failures++; $display("FAIL bypass_data got=%h exp=%h", data_o, {{4{8'h00}}, {4{8'h5A}}, {4{8'h00}}, {4{8'h5A}}});
        end
`else
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL nobypass_valid got=%b exp=0", valid_o); end
`endif
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
`ifdef ITA_OUT_BYPASS_EN
        checks++; if (valid_o !== 1'b0 || usage_o !== '0) begin
            failures++; $display("FAIL bypass_after got valid=%b usage=%0d exp valid=0 usage=0", valid_o, usage_o);
        end
`else
        checks++; if (valid_o !== 1'b1 || usage_o !== UW'(1)) begin
            failures++; $display("FAIL nobypass_after got valid=%b usage=%0d exp valid=1 usage=1", valid_o, usage_o);
        end
        checks++; if (data_o !== {{4{8'h00}}, {4{8'h5A}}, {4{8'h00}}, {4{8'h5A}}}) begin
            failures++; $display("FAIL nobypass_data got=%h exp=%h", data_o, {{4{8'h00}}, {4{8'h5A}}, {4{8'h00}}, {4{8'h5A}}});
        end
`endif
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset_midop();
        apply_reset();
        valid_i = 1'b1; data_i = {16{8'h33}};
        repeat (2) tick();
        valid_i = 1'b0; ready_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || tile_done_o !== 1'b0) begin
            failures++; $display("FAIL midreset_out got valid=%b done=%b exp 0 0", valid_o, tile_done_o);
        end
        checks++; if (usage_o !== '0 || ready_o !== 1'b1) begin
            failures++; $display("FAIL midreset_state got usage=%0d ready=%b exp usage=0 ready=1", usage_o, ready_o);
        end
        ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_masking();
        test_backpressure();
        test_streaming();
        test_clear();
        test_bypass();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
